frame_window_streamer: RTL

Downstream consumer of the ping-pong sample buffer. When a full frame is ready, it claims the filled half and acknowledges it so the writer can move to the other half. It then streams all BUFFER_SIZE samples out in order, each multiplied by a per-index Q1.15 window coefficient, over a valid/ready interface to the transform stage.

---
 rtl/frame_window_pkg.sv | 28 ++
 rtl/frame_window_streamer_window_mac.sv | 71 +++++++
 rtl/frame_window_streamer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/frame_window_pkg.sv
// Shared types and arithmetic helpers for the frame window streamer.
// FRAME_WINDOW_EN selects the windowed datapath in the users of this package.
package frame_window_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   localparam int COEF_FRAC = 15;
   localparam logic signed [63:0] ROUND_C =
      64'sd1 <<< (COEF_FRAC - 1);

   function automatic logic signed [63:0] sat(
      input logic signed [63:0] v,
      input int                 w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/frame_window_streamer_window_mac.sv
// Enable-gated multiply (S2) and round/saturate (S3) stages.
// Without FRAME_WINDOW_EN only S3 remains and passes the sample through.
module window_mac
   import frame_window_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   input  logic                  valid_i,
   input  logic                  last_i,
   input  logic [DATA_WIDTH-1:0] sample_i,
   input  logic [COEF_WIDTH-1:0] coef_i,
   output logic                  valid_o,
   output logic                  last_o,
   output logic [DATA_WIDTH-1:0] data_o
);

`ifdef FRAME_WINDOW_EN
   localparam int PW = DATA_WIDTH + COEF_WIDTH;

   logic [PW-1:0]         prod_q;
   logic                  s2_valid_q;
   logic                  s2_last_q;
   logic signed [63:0]    prod_ext;
   logic signed [63:0]    rnd;
   logic [DATA_WIDTH-1:0] data_d;

   always_comb begin
      prod_ext = 64'($signed(prod_q));
      rnd      = (prod_ext + ROUND_C) >>> COEF_FRAC;
      data_d   = DATA_WIDTH'(sat(rnd, DATA_WIDTH));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prod_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         valid_o    <= 1'b0;
         last_o     <= 1'b0;
         data_o     <= '0;
      end else if (en_i) begin
         prod_q     <= PW'($signed(sample_i)) * PW'($signed(coef_i));
         s2_valid_q <= valid_i;
         s2_last_q  <= last_i;
         valid_o    <= s2_valid_q;
         last_o     <= s2_last_q;
         data_o     <= data_d;
      end
   end
`else
   logic unused_coef;
   assign unused_coef = ^coef_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         data_o  <= '0;
      end else if (en_i) begin
         valid_o <= valid_i;
         last_o  <= last_i;
         data_o  <= sample_i;
      end
   end
`endif

endmodule

// File: rtl/frame_window_streamer.sv
// Claims a filled ping-pong half and streams it out, optionally windowed.
// Define FRAME_WINDOW_EN for the coefficient RAM and multiplier stage.
module frame_window_streamer
   import frame_window_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int BUFFER_SIZE = 256,
   parameter int COEF_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ready_for_processing,
   input  logic                              buffer_select,
   input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buffer_flat_a,
   input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buffer_flat_b,
   output logic                              ready_ack,
   input  logic                              coef_we,
   input  logic [$clog2(BUFFER_SIZE)-1:0]    coef_addr,
   input  logic [COEF_WIDTH-1:0]             coef_wdata,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [DATA_WIDTH-1:0]             m_data,
   output logic                              m_last,
   output logic                              busy,
   output logic                              overrun,
   input  logic                              overrun_clr
);

   localparam int AW = $clog2(BUFFER_SIZE);
   localparam logic [AW-1:0] LAST_IDX = AW'(BUFFER_SIZE - 1);

   state_e                state_q;
   logic                  sel_q;
   logic [AW-1:0]         rd_idx_q;
   logic                  ack_q;
   logic                  busy_q;
   logic                  ovr_q;
   logic                  s1_valid_q;
   logic                  s1_last_q;
   logic [DATA_WIDTH-1:0] s1_sample_q;
   logic [COEF_WIDTH-1:0] s1_coef;
   logic [DATA_WIDTH-1:0] sample_d;
   logic                  en;

   // The whole pipeline advances only when the output slot can move.
   assign en = !m_valid || m_ready;

   always_comb begin
      sample_d = buffer_flat_a[int'(rd_idx_q)*DATA_WIDTH +: DATA_WIDTH];
      if (sel_q)
         sample_d = buffer_flat_b[int'(rd_idx_q)*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         rd_idx_q    <= '0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         ovr_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_sample_q <= '0;
      end else begin
         ack_q <= 1'b0;
         if (busy_q && ready_for_processing && !ack_q)
            ovr_q <= 1'b1;
         else if (overrun_clr)
            ovr_q <= 1'b0;
         if (en)
            s1_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ready_for_processing) begin
                  sel_q    <= buffer_select;
                  ack_q    <= 1'b1;
                  rd_idx_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= STREAM;
               end
            end
            STREAM: begin
               if (en) begin
                  s1_valid_q  <= 1'b1;
                  s1_sample_q <= sample_d;
                  s1_last_q   <= (rd_idx_q == LAST_IDX);
                  rd_idx_q    <= rd_idx_q + 1'b1;
                  if (rd_idx_q == LAST_IDX)
                     state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (m_valid && m_ready && m_last) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef FRAME_WINDOW_EN
   logic [COEF_WIDTH-1:0] coef_ram [BUFFER_SIZE];
   logic [COEF_WIDTH-1:0] coef_q;

   // Writes only while idle so a frame never sees a half-updated window.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && coef_we)
         coef_ram[coef_addr] <= coef_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)
         coef_q <= '0;
      else if (state_q == STREAM && en)
         coef_q <= coef_ram[rd_idx_q];
   end

   assign s1_coef = coef_q;
`else
   logic unused_coef;
   assign unused_coef = ^{coef_we, coef_addr, coef_wdata};
   assign s1_coef     = '0;
`endif

   window_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH)
   ) u_mac (
      .clk_i    (clk),
      .reset_i  (reset),
      .en_i     (en),
      .valid_i  (s1_valid_q),
      .last_i   (s1_last_q),
      .sample_i (s1_sample_q),
      .coef_i   (s1_coef),
      .valid_o  (m_valid),
      .last_o   (m_last),
      .data_o   (m_data)
   );

   assign ready_ack = ack_q;
   assign busy      = busy_q;
   assign overrun   = ovr_q;

endmodule
